// File: rtl/combo_pkg.sv
// Shared types and constants for the combination dialer: FSM state encoding,
// symbol values, the reference code and a sizing helper.
package combo_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        PULSE,
        GAP,
        CHECK,
        DONE
    } state_t;

    localparam logic SYM_ZERO = 1'b0;
    localparam logic SYM_ONE  = 1'b1;

    localparam logic [4:0] CODE_DEFAULT = 5'b01011;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/combo_pulse_timer.sv
// Loadable down-counter: load sets the count, then it decrements to zero and
// holds there; expired is high while the count is zero.
module combo_pulse_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/combo_dialer.sv
// Serially dials a latched code into a zero/one button lock, then samples its
// unlocked flag. Define DIALER_PRECLEAR_EN to pulse lock_rst_o before dialing.
module combo_dialer
    import combo_pkg::*;
#(
    parameter int CODE_LEN = 5,
    parameter int PULSE_W  = 2,
    parameter int GAP_W    = 1,
    parameter int CHK_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CODE_LEN-1:0] code_i,
    input  logic                unlocked_i,
    output logic                zero_o,
    output logic                one_o,
    output logic                lock_rst_o,
    output logic                busy,
    output logic                done,
    output logic                pass
);

    localparam int CNT_W = $clog2(max3(PULSE_W, GAP_W, CHK_W) + 1);
    localparam int IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

    // Timer reload values are duration-1: the state lasts until the count hits zero.
    localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(GAP_W - 1);
    localparam logic [CNT_W-1:0] LD_CHK   = CNT_W'(CHK_W - 1);

    state_t              state, state_n;
    logic [CODE_LEN-1:0] shreg;
    logic [IDX_W-1:0]    idx;
    logic                tmr_load;
    logic [CNT_W-1:0]    tmr_val;
    logic                tmr_exp;
    logic                accept;
    logic                shift_en;
    logic                idx_dec;
    logic                pass_set;
    logic                pass_clr;
    logic                sym_n;
`ifdef DIALER_PRECLEAR_EN
    logic                clr_gap, clr_gap_n;
`endif

    combo_pulse_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_exp)
    );

    assign accept = (state == IDLE) && start;
    // The first symbol is taken straight from code_i because shreg loads on the same edge.
    assign sym_n  = (state == IDLE) ? code_i[CODE_LEN-1] : shreg[CODE_LEN-1];

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_n  = state;
        tmr_load = 1'b0;
        tmr_val  = '0;
        shift_en = 1'b0;
        idx_dec  = 1'b0;
        pass_set = 1'b0;
        pass_clr = 1'b0;
`ifdef DIALER_PRECLEAR_EN
        clr_gap_n = clr_gap;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    pass_clr = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = LD_PULSE;
`ifdef DIALER_PRECLEAR_EN
                    state_n   = CLEAR;
                    clr_gap_n = 1'b0;
`else
                    state_n  = PULSE;
`endif
                end
            end
            CLEAR: begin
`ifdef DIALER_PRECLEAR_EN
                if (tmr_exp) begin
                    tmr_load = 1'b1;
                    if (!clr_gap) begin
                        clr_gap_n = 1'b1;
                        tmr_val   = LD_GAP;
                    end else begin
                        state_n = PULSE;
                        tmr_val = LD_PULSE;
                    end
                end
`else
                state_n = IDLE;
`endif
            end
            PULSE: begin
                if (tmr_exp) begin
                    state_n  = GAP;
                    tmr_load = 1'b1;
                    tmr_val  = LD_GAP;
                    shift_en = 1'b1;
                end
            end
            GAP: begin
                if (tmr_exp) begin
                    tmr_load = 1'b1;
                    if (idx == '0) begin
                        state_n = CHECK;
                        tmr_val = LD_CHK;
                    end else begin
                        state_n = PULSE;
                        tmr_val = LD_PULSE;
                        idx_dec = 1'b1;
                    end
                end
            end
            CHECK: begin
                if (unlocked_i) begin
                    pass_set = 1'b1;
                    state_n  = DONE;
                end else if (tmr_exp) begin
                    pass_clr = 1'b1;
                    state_n  = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            shreg  <= '0;
            idx    <= '0;
            pass   <= 1'b0;
            zero_o <= 1'b0;
            one_o  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                shreg <= code_i;
                idx   <= IDX_W'(CODE_LEN - 1);
            end else begin
                if (shift_en) shreg <= shreg << 1;
                if (idx_dec)  idx   <= idx - 1'b1;
            end
            if (pass_clr)      pass <= 1'b0;
            else if (pass_set) pass <= 1'b1;
            zero_o <= (state_n == PULSE) && (sym_n == SYM_ZERO);
            one_o  <= (state_n == PULSE) && (sym_n == SYM_ONE);
            busy   <= (state_n inside {CLEAR, PULSE, GAP, CHECK});
            done   <= (state_n == DONE);
        end
    end

`ifdef DIALER_PRECLEAR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_gap    <= 1'b0;
            lock_rst_o <= 1'b0;
        end else begin
            clr_gap    <= clr_gap_n;
            lock_rst_o <= (state_n == CLEAR) && !clr_gap_n;
        end
    end
`else
    assign lock_rst_o = 1'b0;
`endif

endmodule

// File: tb/tb_combo_dialer.sv
// Directed bench for combo_dialer with a small zero/one lock model on the
// button outputs; honours DIALER_PRECLEAR_EN for the pre-clear prologue.
module tb_combo_dialer;
    import combo_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] code_i = '0;
    logic       unlocked_i;
    logic       zero_o, one_o, lock_rst_o, busy, done, pass;

    int n_cmp = 0;
    int n_err = 0;

    combo_dialer #(
        .CODE_LEN (5),
        .PULSE_W  (2),
        .GAP_W    (1),
        .CHK_W    (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .code_i     (code_i),
        .unlocked_i (unlocked_i),
        .zero_o     (zero_o),
        .one_o      (one_o),
        .lock_rst_o (lock_rst_o),
        .busy       (busy),
        .done       (done),
        .pass       (pass)
    );

    always #5 clk = ~clk;

    // Lock model: records a symbol on each button rising edge and unlocks
    // once the last five symbols equal CODE_DEFAULT.
    logic       lock_en = 1'b0;
    logic       lock_clr = 1'b0;
    logic [4:0] lock_hist = '0;
    int         lock_n = 0;
    logic       lock_unl = 1'b0;
    logic       prev_z = 1'b0, prev_o = 1'b0;

    always @(posedge clk) begin
        prev_z <= zero_o;
        prev_o <= one_o;
        if (lock_clr || lock_rst_o) begin
            lock_hist <= '0;
            lock_n    <= 0;
            lock_unl  <= 1'b0;
        end else if ((zero_o && !prev_z) || (one_o && !prev_o)) begin
            lock_hist <= {lock_hist[3:0], one_o};
            lock_n    <= lock_n + 1;
            lock_unl  <= ({lock_hist[3:0], one_o} == CODE_DEFAULT) && (lock_n >= 4);
        end
    end

    assign unlocked_i = lock_en ? lock_unl : 1'b0;

    int done_cnt = 0;
    int onehot_err = 0;
    always @(negedge clk) begin
        if (zero_o && one_o) onehot_err++;
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start=1 sampled on the next rising edge (edge N); returns in cycle N+1.
    task automatic accept(input logic [4:0] code);
        @(negedge clk);
        code_i = code;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic skip_pre(input string tag);
`ifdef DIALER_PRECLEAR_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check({tag, "_lock_rst"}, lock_rst_o, (i < 2) ? 1 : 0);
            check({tag, "_pre_btn"}, zero_o | one_o, 0);
            check({tag, "_pre_busy"}, busy, 1);
        end
`else
        @(negedge clk);
        check({tag, "_lock_rst_idle"}, lock_rst_o, 0);
        #1;
        @(posedge clk);
        #1;
        // re-align: the negedge above consumed cycle N+1, so step back by
        // sampling the waveform one cycle later in dial_wave via offset
`endif
    endtask

    // Waveform of the five symbols: 15 cycles, index 14 is the first cycle.
    task automatic dial_wave(input string tag, input logic [14:0] zexp, input logic [14:0] oexp);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check({tag, "_zero"}, zero_o, zexp[14-i]);
            check({tag, "_one"}, one_o, oexp[14-i]);
            if (i == 0) begin
                check({tag, "_busy"}, busy, 1);
                check({tag, "_pass_clr"}, pass, 0);
            end
        end
    endtask

    localparam logic [14:0] Z_DEF = 15'b110000110000000;
    localparam logic [14:0] O_DEF = 15'b000110000110110;
    localparam logic [14:0] Z_ONE = 15'b000000000000000;
    localparam logic [14:0] O_ONE = 15'b110110110110110;

    int d0, o0;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_btn", {zero_o, one_o}, 0);
        check("rst_lock_rst", lock_rst_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        lock_clr = 1'b1;
        @(negedge clk);
        lock_clr = 1'b0;

        // 1. Default code with loopback lock -> pass
        lock_en = 1'b1;
        accept(CODE_DEFAULT);
`ifdef DIALER_PRECLEAR_EN
        skip_pre("t1");
`endif
        dial_wave("t1", Z_DEF, O_DEF);
        @(negedge clk);
        check("t1_check_busy", busy, 1);
        check("t1_check_done", done, 0);
        @(negedge clk);
        check("t1_done", done, 1);
        check("t1_done_busy", busy, 0);
        check("t1_pass", pass, 1);
        @(negedge clk);
        check("t1_done_drop", done, 0);
        check("t1_pass_hold", pass, 1);
        check("t1_lock_rst", lock_rst_o, 0);

        // 2. All-ones code, lock never unlocks -> CHECK timeout, pass=0
        lock_en = 1'b0;
        accept(5'b11111);
`ifdef DIALER_PRECLEAR_EN
        skip_pre("t2");
`endif
        dial_wave("t2", Z_ONE, O_ONE);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_chk_busy", busy, 1);
            check("t2_chk_done", done, 0);
        end
        @(negedge clk);
        check("t2_done", done, 1);
        check("t2_pass", pass, 0);
        check("t2_done_busy", busy, 0);

        // 3. start while busy with a new code is ignored
        @(negedge clk);
        lock_clr = 1'b1;
        @(negedge clk);
        lock_clr = 1'b0;
        lock_en = 1'b1;
        d0 = done_cnt;
        accept(CODE_DEFAULT);
`ifdef DIALER_PRECLEAR_EN
        skip_pre("t3");
`endif
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("t3_zero", zero_o, Z_DEF[14-i]);
            check("t3_one", one_o, O_DEF[14-i]);
            if (i == 2) begin
                code_i = 5'b10100;
                start  = 1'b1;
            end
            if (i == 3) start = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("t3_done", done, 1);
        check("t3_pass", pass, 1);
        repeat (4) @(negedge clk);
        check("t3_no_requeue", busy, 0);
        check("t3_done_count", done_cnt - d0, 1);

        // 4. Asynchronous reset during the third PULSE
        @(negedge clk);
        lock_clr = 1'b1;
        @(negedge clk);
        lock_clr = 1'b0;
        d0 = done_cnt;
        accept(CODE_DEFAULT);
`ifdef DIALER_PRECLEAR_EN
        skip_pre("t4");
`endif
        for (int i = 0; i < 7; i++) @(negedge clk);
        check("t4_third_pulse", zero_o, 1);
        rst_n = 1'b0;
        #1;
        check("t4_async_btn", {zero_o, one_o}, 0);
        check("t4_async_busy", busy, 0);
        check("t4_async_done", done, 0);
        check("t4_async_pass", pass, 0);
        check("t4_async_lock_rst", lock_rst_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("t4_idle_busy", busy, 0);
        check("t4_idle_btn", {zero_o, one_o}, 0);
        check("t4_pass", pass, 0);
        check("t4_no_done", done_cnt - d0, 0);

        // 5. start held high across two dials
        lock_en = 1'b0;
        o0 = onehot_err;
        d0 = done_cnt;
        @(negedge clk);
        code_i = 5'b11111;
        start  = 1'b1;
        @(posedge clk);
        #1;
`ifdef DIALER_PRECLEAR_EN
        skip_pre("t5");
`endif
        dial_wave("t5", Z_ONE, O_ONE);
        repeat (4) @(negedge clk);
        @(negedge clk);
        check("t5_done1", done, 1);
        check("t5_done1_busy", busy, 0);
        @(negedge clk);
        check("t5_idle_busy", busy, 0);
        check("t5_idle_done", done, 0);
        @(negedge clk);
        check("t5_rearm_busy", busy, 1);
`ifdef DIALER_PRECLEAR_EN
        check("t5_rearm_lock_rst", lock_rst_o, 1);
`else
        check("t5_rearm_one", one_o, 1);
`endif
        start = 1'b0;
        repeat (40) @(negedge clk);
        check("t5_done_count", done_cnt - d0, 2);
        check("t5_busy_end", busy, 0);
        check("t5_onehot", onehot_err - o0, 0);
        check("all_onehot", onehot_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
